// File: rtl/icu_pkg.sv
// Shared types for the 1-bit industrial control unit core: opcodes, FSM states
// and the opcode classification used by the fetch/execute sequencer.
package icu_pkg;

  typedef enum logic [3:0] {
    OpNopo = 4'h0,
    OpLd   = 4'h1,
    OpLdc  = 4'h2,
    OpAnd  = 4'h3,
    OpAndc = 4'h4,
    OpOr   = 4'h5,
    OpOrc  = 4'h6,
    OpXnor = 4'h7,
    OpSto  = 4'h8,
    OpStoc = 4'h9,
    OpIen  = 4'hA,
    OpOen  = 4'hB,
    OpJmp  = 4'hC,
    OpRtn  = 4'hD,
    OpSkz  = 4'hE,
    OpNopf = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StExec  = 2'd1,
    StIoReq = 2'd2,
    StIoRel = 2'd3
  } state_t;

  // Instructions that run a handshake with the IO block (stores may still be
  // demoted to a NOP by the core when output is disabled).
  function automatic logic is_io_op(opcode_t op);
    return op inside {OpLd, OpLdc, OpAnd, OpAndc, OpOr, OpOrc, OpXnor,
                      OpSto, OpStoc, OpIen, OpOen};
  endfunction

endpackage

// File: rtl/icu_logic_unit.sv
// Combinational result-register update for the load and logic instructions;
// every other opcode passes the current result through unchanged.
module icu_logic_unit
  import icu_pkg::*;
(
  input  opcode_t op_i,
  input  logic    rr_i,
  input  logic    d_i,
  output logic    rr_o
);

  always_comb begin
    rr_o = rr_i;
    case (op_i)
      OpLd:    rr_o = d_i;
      OpLdc:   rr_o = ~d_i;
      OpAnd:   rr_o = rr_i & d_i;
      OpAndc:  rr_o = rr_i & ~d_i;
      OpOr:    rr_o = rr_i | d_i;
      OpOrc:   rr_o = rr_i | ~d_i;
      OpXnor:  rr_o = ~(rr_i ^ d_i);
      default: rr_o = rr_i;
    endcase
  end

endmodule

// File: rtl/icu_core.sv
// Execution core of the 1-bit control unit: fetches from synchronous program
// memory, holds RR/IEN/OEN/skip and drives the four-phase IO handshake.
module icu_core
  import icu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned PC_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [PC_WIDTH-1:0]   prog_addr,
  input  logic [ADDR_WIDTH+3:0] prog_data,
  output logic [ADDR_WIDTH-1:0] io_address,
  output logic                  io_write,
  output logic                  io_wdata,
  input  logic                  io_rdata,
  output logic                  io_req,
  input  logic                  io_ack,
  output logic                  rr,
  output logic                  flag_o,
  output logic                  flag_f,
  output logic                  jmp,
  output logic                  rtn
);

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d, pc_inc;
  logic                  rr_q, rr_d;
  logic                  ien_q, ien_d;
  logic                  oen_q, oen_d;
  logic                  skip_q, skip_d;
  opcode_t               op_q, op_d;
  logic [ADDR_WIDTH-1:0] io_address_q, io_address_d;
  logic                  io_write_q, io_write_d;
  logic                  io_wdata_q, io_wdata_d;
  logic                  flag_o_q, flag_o_d;
  logic                  flag_f_q, flag_f_d;
  logic                  jmp_q, jmp_d;
  logic                  rtn_q, rtn_d;

  opcode_t               op_dec;
  logic [ADDR_WIDTH-1:0] addr_dec;
  logic                  is_store;
  logic                  d_masked;
  logic                  rr_lu;

  assign op_dec   = opcode_t'(prog_data[ADDR_WIDTH +: 4]);
  assign addr_dec = prog_data[ADDR_WIDTH-1:0];
  assign is_store = (op_dec == OpSto) || (op_dec == OpStoc);
  assign pc_inc   = pc_q + PC_WIDTH'(1);
  assign d_masked = io_rdata & ien_q;

  icu_logic_unit u_logic_unit (
    .op_i (op_q),
    .rr_i (rr_q),
    .d_i  (d_masked),
    .rr_o (rr_lu)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    rr_d         = rr_q;
    ien_d        = ien_q;
    oen_d        = oen_q;
    skip_d       = skip_q;
    op_d         = op_q;
    io_address_d = io_address_q;
    io_write_d   = io_write_q;
    io_wdata_d   = io_wdata_q;
    flag_o_d     = 1'b0;
    flag_f_d     = 1'b0;
    jmp_d        = 1'b0;
    rtn_d        = 1'b0;

    unique case (state_q)
      StFetch: state_d = StExec;

      StExec: begin
        state_d = StFetch;
        pc_d    = pc_inc;
        if (skip_q) begin
          // A skipped instruction never sets skip itself, so skips do not chain.
          skip_d = 1'b0;
        end else if (is_io_op(op_dec) && (oen_q || !is_store)) begin
          state_d      = StIoReq;
          pc_d         = pc_q;
          op_d         = op_dec;
          io_address_d = addr_dec;
          io_write_d   = is_store;
          io_wdata_d   = is_store & (rr_q ^ (op_dec == OpStoc));
        end else begin
          case (op_dec)
            OpNopo: flag_o_d = 1'b1;
            OpNopf: flag_f_d = 1'b1;
            OpJmp: begin
              pc_d  = PC_WIDTH'(addr_dec);
              jmp_d = 1'b1;
            end
            OpRtn: begin
              rtn_d  = 1'b1;
              skip_d = 1'b1;
            end
            OpSkz:   skip_d = ~rr_q;
            default: begin end
          endcase
        end
      end

      StIoReq: begin
        if (io_ack) begin
          rr_d = rr_lu;
          if (op_q == OpIen) ien_d = io_rdata;
          if (op_q == OpOen) oen_d = io_rdata;
          state_d = StIoRel;
        end
      end

      StIoRel: begin
        if (!io_ack) begin
          pc_d    = pc_inc;
          state_d = StFetch;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StFetch;
      pc_q         <= '0;
      rr_q         <= 1'b0;
      ien_q        <= 1'b0;
      oen_q        <= 1'b0;
      skip_q       <= 1'b0;
      op_q         <= OpNopo;
      io_address_q <= '0;
      io_write_q   <= 1'b0;
      io_wdata_q   <= 1'b0;
      flag_o_q     <= 1'b0;
      flag_f_q     <= 1'b0;
      jmp_q        <= 1'b0;
      rtn_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      rr_q         <= rr_d;
      ien_q        <= ien_d;
      oen_q        <= oen_d;
      skip_q       <= skip_d;
      op_q         <= op_d;
      io_address_q <= io_address_d;
      io_write_q   <= io_write_d;
      io_wdata_q   <= io_wdata_d;
      flag_o_q     <= flag_o_d;
      flag_f_q     <= flag_f_d;
      jmp_q        <= jmp_d;
      rtn_q        <= rtn_d;
    end
  end

  assign prog_addr  = pc_q;
  assign io_address = io_address_q;
  assign io_write   = io_write_q;
  assign io_wdata   = io_wdata_q;
  assign io_req     = (state_q == StIoReq);
  assign rr         = rr_q;
  assign flag_o     = flag_o_q;
  assign flag_f     = flag_f_q;
  assign jmp        = jmp_q;
  assign rtn        = rtn_q;

endmodule

// File: tb/tb_icu_core.sv
// Bench for icu_core: program memory and IO responder models, a table of
// single-instruction vectors, directed corner sequences and random programs.
module tb_icu_core;

  localparam int unsigned AW = 4;
  localparam int unsigned PW = 8;
  localparam int ENDPC = 13;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [PW-1:0] prog_addr;
  logic [AW+3:0] prog_data;
  logic [AW-1:0] io_address;
  logic          io_write, io_wdata, io_rdata, io_req, io_ack;
  logic          rr, flag_o, flag_f, jmp, rtn;

  always #5 clk = ~clk;

  icu_core #(.ADDR_WIDTH(AW), .PC_WIDTH(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .io_address (io_address),
    .io_write   (io_write),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .io_req     (io_req),
    .io_ack     (io_ack),
    .rr         (rr),
    .flag_o     (flag_o),
    .flag_f     (flag_f),
    .jmp        (jmp),
    .rtn        (rtn)
  );

  // Program memory: one-cycle synchronous read.
  logic [7:0] mem [256];
  logic       pd_x = 1'b0;
  always @(posedge clk) prog_data <= pd_x ? 'x : mem[prog_addr];

  // IO responder: inputs are read from iomem; writes are observed, not stored.
  logic iomem [16];
  logic resp_en = 1'b1;
  int   ack_dly = -1;
  int   ack_cnt;
  always @(posedge clk) begin
    if (!resp_en || reset) begin
      io_ack  <= 1'b0;
      ack_cnt <= 0;
    end else if (io_req && !io_ack) begin
      if (ack_cnt == 0) begin
        io_ack   <= 1'b1;
        io_rdata <= iomem[io_address];
      end else begin
        ack_cnt <= ack_cnt - 1;
      end
    end else if (!io_req && io_ack) begin
      io_ack <= 1'b0;
    end else if (!io_req) begin
      ack_cnt <= (ack_dly < 0) ? int'($urandom_range(3, 0)) : ack_dly;
    end
  end

  typedef struct packed {
    logic [3:0] addr;
    logic       wr;
    logic       wd;
    logic       rr;
  } txn_t;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input txn_t t);
    return {25'd0, t.addr, t.wr, t.wr & t.wd, t.rr};
  endfunction

  // Monitor: IO transactions (fields at req rise, rr at req fall) and pulses.
  txn_t txn_q[$];
  int   pulse_q[$];
  int   n_rise = 0;
  txn_t cur;
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (io_req && !req_prev) begin
        cur.addr = io_address;
        cur.wr   = io_write;
        cur.wd   = io_wdata;
        n_rise++;
      end else if (io_req) begin
        chk("io hold", 32'({io_address, io_write, io_wdata}), 32'({cur.addr, cur.wr, cur.wd}));
      end
      if (!io_req && req_prev) begin
        cur.rr = rr;
        txn_q.push_back(cur);
      end
      if (flag_o) pulse_q.push_back(0);
      if (flag_f) pulse_q.push_back(1);
      if (jmp) pulse_q.push_back(2);
      if (rtn) pulse_q.push_back(3);
    end
    req_prev = io_req;
  end

  task automatic clear_mon();
    txn_q.delete();
    pulse_q.delete();
    n_rise = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pd_x  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic wait_pc(input logic [7:0] target, input int budget, input string name);
    int n;
    n = 0;
    while (prog_addr !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(prog_addr), 32'(target));
  endtask

  // Reference model: instruction-level interpreter of the program in mem.
  txn_t exp_txn[$];
  int   exp_pulse[$];
  logic exp_rr;

  task automatic run_model();
    int   pc, guard, op, a;
    logic r, ie, oe, sk, raw, d;
    pc = 0; guard = 0; r = 0; ie = 0; oe = 0; sk = 0;
    exp_txn.delete();
    exp_pulse.delete();
    while (!(pc == ENDPC && !sk) && guard < 100) begin
      guard++;
      op = int'(mem[pc][7:4]);
      a  = int'(mem[pc][3:0]);
      if (sk) begin
        sk = 0;
        pc = pc + 1;
      end else begin
        raw = iomem[a];
        d   = raw & ie;
        case (op)
          0:  exp_pulse.push_back(0);
          1:  r = d;
          2:  r = !d;
          3:  r = r & d;
          4:  r = r & !d;
          5:  r = r | d;
          6:  r = r | !d;
          7:  r = (r == d);
          10: ie = raw;
          11: oe = raw;
          12: exp_pulse.push_back(2);
          13: begin exp_pulse.push_back(3); sk = 1; end
          14: sk = !r;
          15: exp_pulse.push_back(1);
          default: begin end
        endcase
        if ((op >= 1 && op <= 7) || op == 10 || op == 11)
          exp_txn.push_back('{addr: 4'(a), wr: 1'b0, wd: 1'b0, rr: r});
        else if ((op == 8 || op == 9) && oe)
          exp_txn.push_back('{addr: 4'(a), wr: 1'b1, wd: (op == 9) ? !r : r, rr: r});
        pc = (op == 12) ? a : pc + 1;
      end
    end
    exp_rr = r;
  endtask

  typedef struct packed {
    logic [3:0] op;
    logic       rr_in;
    logic       ien;
    logic       d;
    logic       exp;
  } vec_t;
  vec_t vecs [15];

  initial begin
    int   n, op, a, k, lim;
    logic req_seen;

    vecs[0]  = '{4'h1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{4'h1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{4'h2, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{4'h2, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{4'h3, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{4'h3, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{4'h4, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{4'h4, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{4'h5, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{4'h5, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{4'h6, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{4'h6, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{4'h7, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{4'h7, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{4'h7, 1'b0, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    for (int i = 0; i < 16; i++) iomem[i] = 1'b1;

    // Reset with undefined program data, then IEN 1, OEN 1, LD 9, STOC 3.
    mem[0] = 8'hA1; mem[1] = 8'hB1; mem[2] = 8'h19; mem[3] = 8'h93; mem[4] = 8'hC4;
    ack_dly = 2;
    pd_x    = 1'b1;
    reset   = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset prog_addr", 32'(prog_addr), 32'd0);
    chk("reset rr", 32'(rr), 32'd0);
    chk("reset io_req", 32'(io_req), 32'd0);
    chk("reset pulses", 32'({flag_o, flag_f, jmp, rtn}), 32'd0);
    chk("reset io_write", 32'(io_write), 32'd0);
    reset = 1'b0;
    pd_x  = 1'b0;
    clear_mon();
    @(negedge clk);
    chk("first fetch addr", 32'(prog_addr), 32'd0);
    wait_pc(8'd4, 200, "store seq end");
    @(negedge clk);
    chk("store seq rr", 32'(rr), 32'd1);
    chk("store seq txn count", 32'(txn_q.size()), 32'd4);
    if (txn_q.size() == 4)
      chk("store seq last txn", pk(txn_q[3]), pk('{addr: 4'd3, wr: 1'b1, wd: 1'b0, rr: 1'b1}));

    // OEN 0 then STO 5: store becomes a two-cycle no-op.
    ack_dly = -1;
    iomem[0] = 1'b0;
    mem[0] = 8'hB0; mem[1] = 8'h85; mem[2] = 8'hC2;
    do_reset();
    wait_pc(8'd1, 100, "oen0 reach sto");
    n = 0;
    req_seen = 1'b0;
    while (prog_addr != 8'd2 && n < 20) begin
      @(negedge clk);
      n++;
      if (io_req) req_seen = 1'b1;
    end
    chk("sto oen0 cycles", 32'(n), 32'd2);
    chk("sto oen0 io_req", 32'(req_seen), 32'd0);
    chk("sto oen0 req count", 32'(n_rise), 32'd1);

    // RR=0, SKZ skips LD 2; NOPF pulses once.
    mem[0] = 8'hE0; mem[1] = 8'h12; mem[2] = 8'hF0; mem[3] = 8'hC3;
    do_reset();
    wait_pc(8'd3, 100, "skz reach");
    @(negedge clk);
    chk("skz no io_req", 32'(n_rise), 32'd0);
    chk("skz pulse count", 32'(pulse_q.size()), 32'd1);
    chk("skz pulse is flag_f", 32'((pulse_q.size() > 0) ? pulse_q[0] : -1), 32'd1);

    // JMP 5 at 0xFE, then NOPO at 0xFF wrapping to 0.
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    mem[8'hFE] = 8'hC5;
    do_reset();
    wait_pc(8'hFE, 600, "reach 0xFE");
    @(negedge clk);
    @(negedge clk);
    chk("jmp pulse", 32'(jmp), 32'd1);
    chk("jmp target", 32'(prog_addr), 32'h05);
    @(negedge clk);
    chk("jmp pulse width", 32'(jmp), 32'd0);
    mem[8'hFE] = 8'hF0;
    mem[8'hFF] = 8'h00;
    do_reset();
    wait_pc(8'hFF, 600, "reach 0xFF");
    @(negedge clk);
    @(negedge clk);
    chk("wrap flag_o", 32'(flag_o), 32'd1);
    chk("wrap pc", 32'(prog_addr), 32'h00);

    // Reset while a request is outstanding and unacknowledged.
    mem[0] = 8'h10;
    iomem[0] = 1'b1;
    resp_en = 1'b0;
    do_reset();
    n = 0;
    while (!io_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort req raised", 32'(io_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort io_req", 32'(io_req), 32'd0);
    chk("abort pc", 32'(prog_addr), 32'd0);
    chk("abort rr", 32'(rr), 32'd0);
    reset = 1'b0;
    resp_en = 1'b1;

    // Table vectors: IEN 0 (=1), LD 1 (=rr_in), IEN 2 (=ien), OP 3 (=d).
    for (int v = 0; v < 15; v++) begin
      mem[0] = 8'hA0; mem[1] = 8'h11; mem[2] = 8'hA2;
      mem[3] = {vecs[v].op, 4'h3}; mem[4] = 8'hC4;
      iomem[0] = 1'b1;
      iomem[1] = vecs[v].rr_in;
      iomem[2] = vecs[v].ien;
      iomem[3] = vecs[v].d;
      do_reset();
      wait_pc(8'd4, 200, $sformatf("vec%0d end", v));
      @(negedge clk);
      chk($sformatf("vec%0d rr", v), 32'(rr), 32'(vecs[v].exp));
    end

    // Random forward-only programs against the interpreter.
    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < 16; i++) iomem[i] = 1'($urandom_range(1, 0));
      for (int i = 0; i < 12; i++) begin
        op = int'($urandom_range(15, 0));
        a  = int'($urandom_range(15, 0));
        if (op == 12) a = int'($urandom_range(12, i + 1));
        mem[i] = {op[3:0], a[3:0]};
      end
      mem[12] = 8'hF0;
      mem[13] = 8'hCD;
      run_model();
      do_reset();
      wait_pc(8'(ENDPC), 500, $sformatf("rand%0d end", p));
      @(negedge clk);
      chk($sformatf("rand%0d txn count", p), 32'(txn_q.size()), 32'(exp_txn.size()));
      lim = (txn_q.size() < exp_txn.size()) ? txn_q.size() : exp_txn.size();
      for (k = 0; k < lim; k++)
        chk($sformatf("rand%0d txn%0d", p, k), pk(txn_q[k]), pk(exp_txn[k]));
      chk($sformatf("rand%0d pulse count", p), 32'(pulse_q.size()), 32'(exp_pulse.size()));
      lim = (pulse_q.size() < exp_pulse.size()) ? pulse_q.size() : exp_pulse.size();
      for (k = 0; k < lim; k++)
        chk($sformatf("rand%0d pulse%0d", p, k), 32'(pulse_q[k]), 32'(exp_pulse[k]));
      chk($sformatf("rand%0d rr", p), 32'(rr), 32'(exp_rr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/icu_core.md
# icu_core

- Instruction-execution core of the MC14500B-style 1-bit industrial control unit.
- Fetches 4-bit-opcode instructions from an external synchronous program memory, keeps the result register and enable flags, and drives the upstream side of the IO block (address, write, data, req/ack).
- Consumes the IO block's read data for load, logic and enable instructions.
- Sits directly upstream of the IO block: its `io_*` ports connect to that block's `address`, `write`, `data_in`, `data_out`, `req_prev` and `ack_prev`.

## Interface
- `ADDR_WIDTH`, 4: IO address field width, equal to the IO block's ADDR_WIDTH.
- `PC_WIDTH`, 8: program counter width; must be ≥ ADDR_WIDTH.
- `clk  in  1  single clock, all state updates on posedge`
- `reset  in  1  synchronous, active-high; clears all state`
- `prog_addr  out  PC_WIDTH  program memory address (= PC)`
- `prog_data  in  4+ADDR_WIDTH  {opcode[3:0], address}, valid one cycle after prog_addr`
- `io_address  out  ADDR_WIDTH  IO block address`
- `io_write  out  1  IO write enable`
- `io_wdata  out  1  data to IO block data_in`
- `io_rdata  in  1  data from IO block data_out`
- `io_req  out  1  four-phase request to IO block req_prev`
- `io_ack  in  1  four-phase acknowledge from IO block ack_prev`
- `rr  out  1  result register`
- `flag_o, flag_f, jmp, rtn  out  1 each  one-cycle pulses`

## Operation
- Opcodes:
  - 0 NOPO: pulse flag_o.
  - 1 LD: RR=D.
  - 2 LDC: RR=~D.
  - 3 AND: RR&=D.
  - 4 ANDC: RR&=~D.
  - 5 OR: RR|=D.
  - 6 ORC: RR|=~D.
  - 7 XNOR: RR=~(RR^D).
  - 8 STO: write RR.
  - 9 STOC: write ~RR.
  - A IEN: IEN=io_rdata.
  - B OEN: OEN=io_rdata.
  - C JMP: PC=zero-extended address field; pulse jmp.
  - D RTN: pulse rtn; skip next.
  - E SKZ: skip next if RR==0.
  - F NOPF: pulse flag_f.
- D = io_rdata & IEN. IEN/OEN reads are unmasked.
- STO/STOC with OEN=0: no IO transaction; instruction completes as a 2-cycle NOP.
- Skip flag set: the next fetched instruction has no effect (no IO, no pulse, no jump), and skip clears.
- PC increments by 1 per instruction, except for a taken JMP. Wraps 2^PC_WIDTH−1 → 0.
- States:
  - FETCH: prog_addr=PC → EXEC.
  - EXEC: decode prog_data. IO instruction → IO_REQ. Otherwise update RR/flags/PC → FETCH.
  - IO_REQ: io_req=1; wait for io_ack=1, then capture io_rdata, update RR/IEN/OEN, drop req → IO_REL.
  - IO_REL: wait for io_ack=0, PC+1 → FETCH.
- Reset values: PC=0, RR=0, IEN=0, OEN=0, skip=0, state=FETCH. All outputs 0, including io_req and the pulses.

## Timing
- Non-IO instruction: 2 cycles (FETCH, EXEC).
- IO instruction: 2 cycles plus handshake, minimum 4 cycles with a zero-wait ack.
- io_address, io_write, io_wdata are registered in EXEC. They are stable from the first cycle io_req is high until the cycle after io_ack falls.
- io_req rises the cycle after EXEC and never drops before io_ack is seen high. The next io_req never rises before io_ack is seen low.
- Pulses are registered: high for exactly the one cycle after EXEC.
- RR updates are visible on `rr` the cycle after EXEC (non-IO) or after the ack-high sample (IO).
- Reset mid-handshake: io_req drops the next cycle and no RR/IEN/OEN update occurs. The IO block tolerates the abandoned request.
- Simultaneous events:
  - JMP while skip is set: skipped, PC+1.
  - SKZ/RTN immediately after a skip: skipped as well; skip does not chain.

## Structure
- `icu_pkg`: `opcode_t` enum (16 opcodes above), `state_t` enum (FETCH, EXEC, IO_REQ, IO_REL), and an `is_io_op` constant function.
- Sub-module `icu_logic_unit`: combinational next-RR from {opcode, RR, D}. The core holds all registers and the FSM.

## Test plan
- Reset with prog_data=X → prog_addr=0, rr=0, io_req=0, all pulses 0. First FETCH on the cycle after reset deasserts.
- Program IEN 1, OEN 1, LD 9, STOC 3 with io_rdata=1 and ack after 2 cycles → rr=1. Final transaction has io_address=3, io_write=1, io_wdata=0.
- OEN=0 then STO 5 → io_req stays 0; PC advances after 2 cycles.
- RR=0, SKZ, LD 2, NOPF → LD issues no io_req, no flag_f from LD. NOPF at PC+2 pulses flag_f once.
- JMP 5 at PC=0xFE → jmp pulse, next prog_addr=0x05. Separately, NOPO at 0xFF → next prog_addr=0x00.
- Reset asserted while io_req=1 and io_ack=0 → io_req=0 next cycle, PC=0, RR unchanged from reset value 0.
